// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: per-pin direction, atomic set/clear, synchronised inputs,
// rise/fall edge interrupts with write-1-to-clear pending bits, one-cycle register port.
module gpio_bank #(
  parameter int NB_IO       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  input  logic             io_req_wr,
  input  logic [2:0]       io_req_addr,
  input  logic [NB_IO-1:0] io_req_wdata,
  output logic             io_req_ready,
  output logic             io_rsp_valid,
  output logic [NB_IO-1:0] io_rsp_rdata,
  output logic [NB_IO-1:0] io_b_gpio_eno,
  output logic [NB_IO-1:0] io_b_gpio_out,
  input  logic [NB_IO-1:0] io_b_gpio_in,
  output logic             io_o_irq
);

  localparam logic [2:0] A_ENO  = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_SET  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
  localparam logic [2:0] A_RISE = 3'd5;
  localparam logic [2:0] A_FALL = 3'd6;
  localparam logic [2:0] A_PEND = 3'd7;

  logic [NB_IO-1:0] eno_q, eno_d, out_q, out_d;
  logic [NB_IO-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [NB_IO-1:0] pend_q, pend_d, prev_q;
  logic [NB_IO-1:0] sync_q [SYNC_STAGES];
  logic [NB_IO-1:0] in_w, eff_w, edge_w, clr_w, rdata_d;
  logic             rsp_valid_q, irq_q, wr_w, rd_w;
  logic [NB_IO-1:0] rsp_rdata_q;

  assign wr_w = io_req_valid & io_req_wr;
  assign rd_w = io_req_valid & ~io_req_wr;

  // Output pins loop back through the synchroniser so IN always shows what the pad carries.
  assign eff_w  = (eno_q & out_q) | (~eno_q & io_b_gpio_in);
  assign in_w   = sync_q[SYNC_STAGES-1];
  assign edge_w = (in_w & ~prev_q & rise_q) | (~in_w & prev_q & fall_q);
  assign clr_w  = (wr_w && io_req_addr == A_PEND) ? io_req_wdata : '0;

  always_comb begin
    eno_d  = eno_q;
    out_d  = out_q;
    rise_d = rise_q;
    fall_d = fall_q;
    // A fresh edge outranks a simultaneous clear.
    pend_d = (pend_q & ~clr_w) | edge_w;
    if (wr_w) begin
      case (io_req_addr)
        A_ENO:   eno_d  = io_req_wdata;
        A_OUT:   out_d  = io_req_wdata;
        A_SET:   out_d  = out_q | io_req_wdata;
        A_CLR:   out_d  = out_q & ~io_req_wdata;
        A_RISE:  rise_d = io_req_wdata;
        A_FALL:  fall_d = io_req_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_w) begin
      case (io_req_addr)
        A_ENO:   rdata_d = eno_q;
        A_OUT:   rdata_d = out_q;
        A_IN:    rdata_d = in_w;
        A_RISE:  rdata_d = rise_q;
        A_FALL:  rdata_d = fall_q;
        A_PEND:  rdata_d = pend_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      eno_q       <= '0;
      out_q       <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      pend_q      <= '0;
      prev_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      eno_q       <= eno_d;
      out_q       <= out_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      pend_q      <= pend_d;
      prev_q      <= in_w;
      rsp_valid_q <= io_req_valid;
      rsp_rdata_q <= rdata_d;
      irq_q       <= |(pend_q & (rise_q | fall_q));
      sync_q[0]   <= eff_w;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign io_req_ready  = 1'b1;
  assign io_rsp_valid  = rsp_valid_q;
  assign io_rsp_rdata  = rsp_rdata_q;
  assign io_b_gpio_eno = eno_q;
  assign io_b_gpio_out = out_q;
  assign io_o_irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: table vectors, hand-timed edge/reset sequences, random traffic
// against a delay-line reference model, and a 32-pin build exercising bit 31.
module tb_gpio_bank;
  localparam int SYNC = 2;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_wr = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0, pads = '0;
  logic       req_ready, rsp_valid, irq;
  logic [7:0] rsp_rdata, eno, out;

  logic        w_valid = 1'b0, w_wr = 1'b0;
  logic [2:0]  w_addr = '0;
  logic [31:0] w_wdata = '0, w_pads = '0;
  logic        w_ready, w_rv, w_irq;
  logic [31:0] w_rdata, w_eno, w_out;

  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  gpio_bank #(.NB_IO(8), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(rst), .io_req_valid(req_valid), .io_req_wr(req_wr),
    .io_req_addr(req_addr), .io_req_wdata(req_wdata), .io_req_ready(req_ready),
    .io_rsp_valid(rsp_valid), .io_rsp_rdata(rsp_rdata), .io_b_gpio_eno(eno),
    .io_b_gpio_out(out), .io_b_gpio_in(pads), .io_o_irq(irq));

  gpio_bank #(.NB_IO(32), .SYNC_STAGES(SYNC)) dut_w (
    .clock(clock), .reset(rst), .io_req_valid(w_valid), .io_req_wr(w_wr),
    .io_req_addr(w_addr), .io_req_wdata(w_wdata), .io_req_ready(w_ready),
    .io_rsp_valid(w_rv), .io_rsp_rdata(w_rdata), .io_b_gpio_eno(w_eno),
    .io_b_gpio_out(w_out), .io_b_gpio_in(w_pads), .io_o_irq(w_irq));

  // Reference model for the 8-pin instance: IN is the effective pin value delayed by SYNC edges.
  logic [7:0] m_eno, m_out, m_rise, m_fall, m_pend, m_rdata;
  logic       m_rv, m_irq;
  logic [7:0] hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_eno = 0; m_out = 0; m_rise = 0; m_fall = 0; m_pend = 0;
    m_rdata = 0; m_rv = 0; m_irq = 0;
    hist = {};
    repeat (SYNC + 1) hist.push_back(8'h00);
  endtask

  task automatic model_step();
    logic [7:0] in_now, prev_now, eff, edges, clr, n_eno, n_out, n_rise, n_fall;
    if (rst) begin
      model_reset();
      return;
    end
    in_now   = hist[1];
    prev_now = hist[0];
    eff      = (m_eno & m_out) | (~m_eno & pads);
    edges    = (in_now & ~prev_now & m_rise) | (~in_now & prev_now & m_fall);
    m_rv     = req_valid;
    m_rdata  = 8'h00;
    if (req_valid && !req_wr) begin
      case (req_addr)
        3'd0: m_rdata = m_eno;
        3'd1: m_rdata = m_out;
        3'd2: m_rdata = in_now;
        3'd5: m_rdata = m_rise;
        3'd6: m_rdata = m_fall;
        3'd7: m_rdata = m_pend;
        default: m_rdata = 8'h00;
      endcase
    end
    clr = 0; n_eno = m_eno; n_out = m_out; n_rise = m_rise; n_fall = m_fall;
    if (req_valid && req_wr) begin
      case (req_addr)
        3'd0: n_eno  = req_wdata;
        3'd1: n_out  = req_wdata;
        3'd3: n_out  = m_out | req_wdata;
        3'd4: n_out  = m_out & ~req_wdata;
        3'd5: n_rise = req_wdata;
        3'd6: n_fall = req_wdata;
        3'd7: clr    = req_wdata;
        default: ;
      endcase
    end
    m_irq  = (m_pend & (m_rise | m_fall)) != 0;
    m_pend = (m_pend & ~clr) | edges;
    m_eno = n_eno; m_out = n_out; m_rise = n_rise; m_fall = n_fall;
    hist.push_back(eff);
    void'(hist.pop_front());
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    chk("model_eno", eno, m_eno);
    chk("model_out", out, m_out);
    chk("model_irq", irq, m_irq);
    chk("model_rsp_valid", rsp_valid, m_rv);
    if (m_rv) chk("model_rdata", rsp_rdata, m_rdata);
  endtask

  task automatic req(input logic wr, input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    cycle();
    req_valid = 1'b0; req_wr = 1'b0; req_wdata = 8'h00;
  endtask

  task automatic wreq(input logic wr, input logic [2:0] a, input logic [31:0] d);
    w_valid = 1'b1; w_wr = wr; w_addr = a; w_wdata = d;
    cycle();
    w_valid = 1'b0; w_wr = 1'b0; w_wdata = 32'h0;
  endtask

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [7:0] exp_eno;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 3'd5, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 3'd6, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 3'd7, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 3'd0, 8'hF0, 8'h00, 8'hF0, 8'h00};
    vecs[6]  = '{1'b1, 3'd1, 8'hA0, 8'h00, 8'hF0, 8'hA0};
    vecs[7]  = '{1'b1, 3'd3, 8'h05, 8'h00, 8'hF0, 8'hA5};
    vecs[8]  = '{1'b1, 3'd4, 8'h80, 8'h00, 8'hF0, 8'h25};
    vecs[9]  = '{1'b0, 3'd1, 8'h00, 8'h25, 8'hF0, 8'h25};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 8'hF0, 8'hF0, 8'h25};
    vecs[11] = '{1'b0, 3'd3, 8'h00, 8'h00, 8'hF0, 8'h25};
    vecs[12] = '{1'b0, 3'd4, 8'h00, 8'h00, 8'hF0, 8'h25};
    vecs[13] = '{1'b1, 3'd2, 8'hFF, 8'h00, 8'hF0, 8'h25};
    vecs[14] = '{1'b0, 3'd2, 8'h00, 8'h20, 8'hF0, 8'h25};
    vecs[15] = '{1'b1, 3'd6, 8'h3C, 8'h00, 8'hF0, 8'h25};
    vecs[16] = '{1'b1, 3'd6, 8'h00, 8'h00, 8'hF0, 8'h25};

    model_reset();
    rst = 1'b1;
    cycle(); cycle();
    chk("reset_eno", eno, 8'h00);
    chk("reset_irq", irq, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("ready", req_ready, 1'b1);
    rst = 1'b0;
    cycle();

    foreach (vecs[i]) begin
      req(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1'b1);
      chk($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_eno", i), eno, vecs[i].exp_eno);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      chk($sformatf("vec%0d_irq", i), irq, 1'b0);
    end
    cycle();
    chk("idle_rsp_valid", rsp_valid, 1'b0);

    // Rising edge on pad0: pending appears exactly SYNC+1 edges after the pad moves.
    req(1'b1, 3'd5, 8'h01);
    pads = 8'h01;
    cycle(); cycle();
    req(1'b0, 3'd7, 8'h00);
    chk("rise_pend_early", rsp_rdata, 8'h00);
    chk("rise_irq_early", irq, 1'b0);
    req(1'b0, 3'd7, 8'h00);
    chk("rise_pend", rsp_rdata, 8'h01);
    chk("rise_irq", irq, 1'b1);
    req(1'b1, 3'd7, 8'h01);
    req(1'b0, 3'd7, 8'h00);
    chk("rise_pend_cleared", rsp_rdata, 8'h00);
    chk("rise_irq_cleared", irq, 1'b0);

    // Falling edge on pad1 coinciding with a clear of the same bit.
    req(1'b1, 3'd6, 8'h02);
    pads = 8'h03;
    repeat (4) cycle();
    req(1'b0, 3'd7, 8'h00);
    chk("fall_pend_quiet", rsp_rdata, 8'h00);
    pads = 8'h01;
    cycle(); cycle();
    req(1'b1, 3'd7, 8'h02);
    req(1'b0, 3'd7, 8'h00);
    chk("fall_set_wins", rsp_rdata, 8'h02);
    chk("fall_irq", irq, 1'b1);
    req(1'b1, 3'd7, 8'h02);
    req(1'b0, 3'd7, 8'h00);
    chk("fall_cleared", rsp_rdata, 8'h00);
    chk("fall_irq_cleared", irq, 1'b0);

    // Pad3 toggles with all enables off: nothing recorded.
    req(1'b1, 3'd5, 8'h00);
    req(1'b1, 3'd6, 8'h00);
    req(1'b1, 3'd7, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      pads = pads ^ 8'h08;
      repeat (3) cycle();
    end
    req(1'b0, 3'd7, 8'h00);
    chk("disabled_pend", rsp_rdata, 8'h00);
    chk("disabled_irq", irq, 1'b0);

    // Back-to-back reads with reset landing on the third.
    req(1'b1, 3'd5, 8'h01);
    req_valid = 1'b1; req_wr = 1'b0;
    req_addr = 3'd0; cycle();
    chk("b2b_rsp0", rsp_rdata, 8'hF0);
    req_addr = 3'd1; cycle();
    chk("b2b_rsp1_valid", rsp_valid, 1'b1);
    chk("b2b_rsp1", rsp_rdata, 8'h25);
    req_addr = 3'd5; rst = 1'b1; cycle();
    chk("b2b_reset_valid", rsp_valid, 1'b0);
    chk("b2b_reset_rdata", rsp_rdata, 8'h00);
    chk("b2b_reset_eno", eno, 8'h00);
    chk("b2b_reset_out", out, 8'h00);
    chk("b2b_reset_irq", irq, 1'b0);
    req_addr = 3'd5; rst = 1'b0; cycle();
    chk("b2b_after_valid", rsp_valid, 1'b1);
    chk("b2b_after_rise", rsp_rdata, 8'h00);
    req_valid = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 149) == 0);
      req_valid = $urandom_range(0, 2) != 0;
      req_wr    = $urandom_range(0, 1);
      req_addr  = 3'($urandom_range(0, 7));
      req_wdata = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pads = 8'($urandom);
      cycle();
    end
    rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0; cycle();

    // 32-pin build, bit 31.
    chk("w_ready", w_ready, 1'b1);
    wreq(1'b1, 3'd0, 32'h8000_0000);
    wreq(1'b1, 3'd1, 32'h0000_0001);
    wreq(1'b1, 3'd3, 32'h8000_0000);
    chk("w_set_out", w_out, 32'h8000_0001);
    wreq(1'b1, 3'd4, 32'h0000_0001);
    chk("w_clr_out", w_out, 32'h8000_0000);
    chk("w_eno", w_eno, 32'h8000_0000);
    repeat (3) cycle();
    wreq(1'b0, 3'd2, 32'h0);
    chk("w_in_loopback", w_rdata, 32'h8000_0000);
    wreq(1'b1, 3'd0, 32'h0);
    wreq(1'b1, 3'd5, 32'h8000_0000);
    repeat (4) cycle();
    wreq(1'b0, 3'd7, 32'h0);
    chk("w_pend_quiet", w_rdata, 32'h0);
    w_pads = 32'h8000_0000;
    repeat (3) cycle();
    wreq(1'b0, 3'd7, 32'h0);
    chk("w_pend31", w_rdata, 32'h8000_0000);
    chk("w_irq", w_irq, 1'b1);
    wreq(1'b1, 3'd7, 32'h8000_0000);
    wreq(1'b0, 3'd7, 32'h0);
    chk("w_pend_cleared", w_rdata, 32'h0);
    chk("w_irq_cleared", w_irq, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
